// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared state encodings for the serial word transmitter family
//
// Holds the FSM state type and its width so the matching serial receivers
// and their benches decode the same codes.

package serial_word_tx_pkg;

  localparam int STATE_W = 2;

  // 2'b11 is deliberately left unnamed; the FSM treats it as a stray code
  // and recovers to IDLE on the next edge.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter with start/busy/done handshake
//
// Ports:
//   clk      system clock, all state changes on posedge
//   reset    asynchronous active-low reset
//   start    request to send data_in, only looked at in IDLE
//   data_in  WIDTH-bit word, captured on the accepting edge
//   hold     freezes shifting while in SHIFT
//   out      serial data line (registered, Moore)
//   busy     high while bits are being driven
//   done     one-cycle pulse after the last bit

module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             hold,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // The next bit always sits at the output end, so shifting moves the
  // register one place toward that end with a zero filling the far side.
  logic [WIDTH-1:0] sreg_shifted;
  logic             sreg_head;

  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      sreg_head    = sreg[WIDTH-1];
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      sreg_head    = sreg[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs depend only on registered state, so out has no path from any
  // input and drops to zero the moment reset clears the state register.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    out       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt  = data_in;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        busy = 1'b1;
        out  = sreg_head;
        if (!hold) begin
          sreg_nxt = sreg_shifted;
          // The count stops at the last index; the state leaves SHIFT
          // there, so it never needs to wrap.
          if (cnt == LAST_CNT) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
